// File: rtl/rx_axis_frame_fifo_pkg.sv
// Shared types for the Ethernet RX store-and-forward frame FIFO.
// Holds the write-side frame state and the width helper used by the interface and the top level.
package rx_axis_frame_fifo_pkg;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_FRAME = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_e;

    // AXI-Stream carries one keep bit per data byte.
    function automatic int keep_width_f(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/rx_axis_frame_fifo_if.sv
// AXI-Stream bundle used on both sides of the RX frame FIFO.
// The master drives the payload and valid; the slave drives ready.
interface rx_axis_frame_fifo_if
    import rx_axis_frame_fifo_pkg::*;
#(
    parameter int data_width_p = 64
) ();

    localparam int keep_width_lp = keep_width_f(data_width_p);

    logic [data_width_p-1:0]  tdata;
    logic [keep_width_lp-1:0] tkeep;
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;
    logic                     tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read register-file storage with asynchronous read.
// The write is clocked; the read port returns the addressed entry in the same cycle.
module bsg_mem_1r1w #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [$clog2(els_p)-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [$clog2(els_p)-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    // NOTE: the array has no reset; pointers decide which entries are meaningful, and
    // leaving it unreset lets synthesis map it onto plain storage.
    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/rx_axis_frame_fifo.sv
// Store-and-forward RX frame FIFO: accepts MAC beats without backpressure, commits a frame only on
// a clean tlast, and rolls back bad or overflowing frames so the DMA side sees only good frames.
module rx_axis_frame_fifo
    import rx_axis_frame_fifo_pkg::*;
#(
    parameter int axis_data_width_p = 64,
    parameter int els_p             = 512,
    parameter int cnt_width_p       = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    rx_axis_frame_fifo_if.slave     s_axis,
    rx_axis_frame_fifo_if.master    m_axis,
    output logic [cnt_width_p-1:0]  good_frames_o,
    output logic [cnt_width_p-1:0]  bad_frames_o,
    output logic [cnt_width_p-1:0]  ovf_frames_o
);

    localparam int keep_width_lp  = keep_width_f(axis_data_width_p);
    localparam int addr_width_lp  = $clog2(els_p);
    localparam int ptr_width_lp   = addr_width_lp + 1;
    localparam int entry_width_lp = axis_data_width_p + keep_width_lp + 1;

    typedef logic [ptr_width_lp-1:0] ptr_t;
    typedef logic [cnt_width_p-1:0]  cnt_t;

    localparam ptr_t els_lp = ptr_t'(els_p);

    wr_state_e wr_state_q, wr_state_d;
    ptr_t      rd_ptr_q, rd_ptr_d;
    ptr_t      wr_commit_q, wr_commit_d;
    ptr_t      wr_cur_q, wr_cur_d;
    cnt_t      good_q, good_d;
    cnt_t      bad_q, bad_d;
    cnt_t      ovf_q, ovf_d;

    logic                      full;
    logic                      avail;
    logic                      read_fire;
    logic                      mem_w_v;
    logic [entry_width_lp-1:0] mem_w_data;
    logic [entry_width_lp-1:0] mem_r_data;

    // Pointers carry a wrap bit, so a difference of exactly els_p means every slot is taken.
    assign full      = (ptr_t'(wr_cur_q - rd_ptr_q)) == els_lp;
    assign avail     = wr_commit_q != rd_ptr_q;
    assign read_fire = avail & m_axis.tready;

    assign mem_w_data = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};

    // NOTE: every signal assigned here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_commit_d = wr_commit_q;
        wr_cur_d    = wr_cur_q;
        good_d      = good_q;
        bad_d       = bad_q;
        ovf_d       = ovf_q;
        mem_w_v     = 1'b0;
        rd_ptr_d    = rd_ptr_q + ptr_t'(read_fire);

        if (s_axis.tvalid) begin
            unique case (wr_state_q)
                WR_IDLE, WR_FRAME: begin
                    if (full) begin
                        wr_cur_d = wr_commit_q;
                        if (s_axis.tlast) begin
                            ovf_d      = ovf_q + cnt_t'(1);
                            wr_state_d = WR_IDLE;
                        end else begin
                            wr_state_d = WR_DROP;
                        end
                    end else begin
                        mem_w_v = 1'b1;
                        if (s_axis.tlast) begin
                            wr_state_d = WR_IDLE;
                            if (s_axis.tuser) begin
                                wr_cur_d = wr_commit_q;
                                bad_d    = bad_q + cnt_t'(1);
                            end else begin
                                wr_cur_d    = wr_cur_q + ptr_t'(1);
                                wr_commit_d = wr_cur_q + ptr_t'(1);
                                good_d      = good_q + cnt_t'(1);
                            end
                        end else begin
                            wr_cur_d   = wr_cur_q + ptr_t'(1);
                            wr_state_d = WR_FRAME;
                        end
                    end
                end
                WR_DROP: begin
                    // Overflow outranks tuser: a dropped frame counts only as an overflow.
                    if (s_axis.tlast) begin
                        ovf_d      = ovf_q + cnt_t'(1);
                        wr_state_d = WR_IDLE;
                    end
                end
                default: wr_state_d = WR_IDLE;
            endcase
        end
    end

    // NOTE: reset is sampled at the clock edge, and all state uses non-blocking assignments so
    // every flop sees the pre-edge values of its neighbours.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_state_q  <= WR_IDLE;
            rd_ptr_q    <= '0;
            wr_commit_q <= '0;
            wr_cur_q    <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            ovf_q       <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_commit_q <= wr_commit_d;
            wr_cur_q    <= wr_cur_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            ovf_q       <= ovf_d;
        end
    end

    bsg_mem_1r1w #(
        .width_p (entry_width_lp),
        .els_p   (els_p)
    ) mem (
        .w_clk_i  (clk_i),
        .w_v_i    (mem_w_v & reset_n_i),
        .w_addr_i (wr_cur_q[addr_width_lp-1:0]),
        .w_data_i (mem_w_data),
        .r_addr_i (rd_ptr_q[addr_width_lp-1:0]),
        .r_data_o (mem_r_data)
    );

    assign s_axis.tready = 1'b1;
    assign m_axis.tvalid = avail;
    assign m_axis.tuser  = 1'b0;
    assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = mem_r_data;

    assign good_frames_o = good_q;
    assign bad_frames_o  = bad_q;
    assign ovf_frames_o  = ovf_q;

endmodule

// File: tb/tb_rx_axis_frame_fifo.sv
// Directed bench for rx_axis_frame_fifo with an 8-entry buffer: a per-cycle vector table for
// streaming/stall behaviour plus hand sequences for bad frames, overflow, full-depth and reset.
module tb_rx_axis_frame_fifo;

    localparam int dw_lp = 64;
    localparam int kw_lp = 8;
    localparam int cw_lp = 16;

    typedef logic [73:0] obs_t;

    typedef struct {
        logic             s_valid;
        logic [dw_lp-1:0] s_data;
        logic [kw_lp-1:0] s_keep;
        logic             s_last;
        logic             s_user;
        logic             m_ready;
        logic             e_valid;
        logic [dw_lp-1:0] e_data;
        logic [kw_lp-1:0] e_keep;
        logic             e_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [cw_lp-1:0] good, bad, ovf;

    int n_tests = 0;
    int n_fail  = 0;

    rx_axis_frame_fifo_if #(.data_width_p(dw_lp)) s_if ();
    rx_axis_frame_fifo_if #(.data_width_p(dw_lp)) m_if ();

    rx_axis_frame_fifo #(
        .axis_data_width_p (dw_lp),
        .els_p             (8),
        .cnt_width_p       (cw_lp)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (rst_n),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .good_frames_o (good),
        .bad_frames_o  (bad),
        .ovf_frames_o  (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t pack_out(input logic v, input logic l, input logic [kw_lp-1:0] k,
                                      input logic [dw_lp-1:0] d);
        return v ? {1'b1, l, k, d} : '0;
    endfunction

    function automatic vec_t mk(input logic sv, input logic [dw_lp-1:0] sd, input logic [kw_lp-1:0] sk,
                                input logic sl, input logic su, input logic mr, input logic ev,
                                input logic [dw_lp-1:0] ed, input logic [kw_lp-1:0] ek, input logic el);
        vec_t r;
        r.s_valid = sv; r.s_data = sd; r.s_keep = sk; r.s_last = sl; r.s_user = su;
        r.m_ready = mr; r.e_valid = ev; r.e_data = ed; r.e_keep = ek; r.e_last = el;
        return r;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [dw_lp-1:0] d, input logic [kw_lp-1:0] k, input logic l,
                        input logic u);
        s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tuser = u;
        step();
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        m_if.tready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic expect_beat(input string name, input logic [dw_lp-1:0] d,
                               input logic [kw_lp-1:0] k, input logic l);
        check(name, pack_out(m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata), pack_out(1'b1, l, k, d));
    endtask

    task automatic expect_idle(input string name);
        check(name, pack_out(m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata), '0);
    endtask

    task automatic expect_counts(input string name, input int g, input int b, input int o);
        check({name, " good"}, obs_t'(good), obs_t'(g));
        check({name, " bad"},  obs_t'(bad),  obs_t'(b));
        check({name, " ovf"},  obs_t'(ovf),  obs_t'(o));
    endtask

    vec_t vecs[17];

    initial begin
        logic saw_out;
        // Good 3-beat frame, then drain.
        vecs[0]  = mk(1, 64'hA0, 8'hFF, 0, 0, 1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 64'hA1, 8'hFF, 0, 0, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 64'hA2, 8'h0F, 1, 0, 1, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 1, 1, 64'hA0, 8'hFF, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 1, 1, 64'hA1, 8'hFF, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 1, 1, 64'hA2, 8'h0F, 1);
        vecs[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // Back-to-back 2-beat frames with tready toggling; data must hold during stalls.
        vecs[7]  = mk(1, 64'hB0, 8'hFF, 0, 0, 1, 0, 0, 0, 0);
        vecs[8]  = mk(1, 64'hB1, 8'h3F, 1, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 64'hC0, 8'hFF, 0, 0, 1, 1, 64'hB0, 8'hFF, 0);
        vecs[10] = mk(1, 64'hC1, 8'h01, 1, 0, 0, 1, 64'hB1, 8'h3F, 1);
        vecs[11] = mk(0, 0, 0, 0, 0, 1, 1, 64'hB1, 8'h3F, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 64'hC0, 8'hFF, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 1, 1, 64'hC0, 8'hFF, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, 64'hC1, 8'h01, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 1, 1, 64'hC1, 8'h01, 1);
        vecs[16] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        s_if.tdata = '0; s_if.tkeep = '0;
        do_reset();
        expect_idle("reset tvalid");
        expect_counts("reset", 0, 0, 0);
        check("tready/tuser constants", obs_t'({s_if.tready, m_if.tuser}), obs_t'(2'b10));

        for (int i = 0; i < 17; i++) begin
            s_if.tvalid = vecs[i].s_valid; s_if.tdata = vecs[i].s_data; s_if.tkeep = vecs[i].s_keep;
            s_if.tlast = vecs[i].s_last; s_if.tuser = vecs[i].s_user; m_if.tready = vecs[i].m_ready;
            check($sformatf("vec %0d", i),
                  pack_out(m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata),
                  pack_out(vecs[i].e_valid, vecs[i].e_last, vecs[i].e_keep, vecs[i].e_data));
            step();
        end
        expect_counts("table", 3, 0, 0);

        // Bad 4-beat frame is rolled back; following 1-beat good frame lands in its place.
        do_reset();
        m_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) beat(64'hBAD0 + 64'(i), 8'hFF, i == 3, i == 3);
        expect_idle("bad frame hidden");
        beat(64'hD0, 8'h0F, 1'b1, 1'b0);
        s_if.tvalid = 1'b0;
        expect_beat("single beat frame", 64'hD0, 8'h0F, 1'b1);
        idle();
        expect_idle("after single beat");
        expect_counts("bad frame", 1, 1, 0);

        // Overflow: 6-beat frame fits, second frame overflows at its 3rd beat.
        do_reset();
        for (int i = 0; i < 6; i++) beat(64'hE0 + 64'(i), 8'hFF, i == 5, 1'b0);
        for (int i = 0; i < 5; i++) beat(64'hF0 + 64'(i), 8'hFF, i == 4, 1'b0);
        idle();
        expect_counts("overflow", 1, 0, 1);
        m_if.tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_beat($sformatf("ovf drain %0d", i), 64'hE0 + 64'(i), 8'hFF, i == 5);
            step();
        end
        expect_idle("ovf drain end");

        // Exactly els_p beats fit; els_p+1 beats are dropped.
        do_reset();
        for (int i = 0; i < 8; i++) beat(64'h80 + 64'(i), 8'hFF, i == 7, 1'b0);
        idle();
        expect_counts("full depth", 1, 0, 0);
        m_if.tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_beat($sformatf("full drain %0d", i), 64'h80 + 64'(i), 8'hFF, i == 7);
            step();
        end
        expect_idle("full drain end");
        saw_out = 1'b0;
        for (int i = 0; i < 9; i++) begin
            saw_out |= m_if.tvalid;
            beat(64'h90 + 64'(i), 8'hFF, i == 8, 1'b0);
        end
        s_if.tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            saw_out |= m_if.tvalid;
            step();
        end
        check("9-beat frame no output", obs_t'(saw_out), '0);
        expect_counts("9-beat frame", 1, 0, 1);

        // Reset mid-frame, with a tlast beat presented during reset.
        do_reset();
        m_if.tready = 1'b1;
        beat(64'h70, 8'hFF, 1'b0, 1'b0);
        beat(64'h71, 8'hFF, 1'b0, 1'b0);
        rst_n = 1'b0;
        beat(64'h72, 8'hFF, 1'b1, 1'b0);
        rst_n = 1'b1;
        s_if.tvalid = 1'b0;
        expect_idle("mid-frame reset tvalid");
        expect_counts("mid-frame reset", 0, 0, 0);
        beat(64'h60, 8'hFF, 1'b0, 1'b0);
        beat(64'h61, 8'h07, 1'b1, 1'b0);
        s_if.tvalid = 1'b0;
        expect_beat("post-reset beat 0", 64'h60, 8'hFF, 1'b0);
        step();
        expect_beat("post-reset beat 1", 64'h61, 8'h07, 1'b1);
        step();
        expect_idle("post-reset end");
        expect_counts("post-reset", 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
